// File: rtl/rank_scatter_buf.sv
// Rank-scatter buffer: writes each (data, rank) pair into slot[rank], then drains
// the frame in rank order. Optional duplicate-rank check under RANK_SCATTER_DUP_CHK_EN.
module rank_scatter_buf #(
  parameter int DATASIZE = 8,
  parameter int NUM      = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                vld_in,
  output logic                rdy_in,
  input  logic [DATASIZE-1:0] din,
  input  logic [4:0]          score_in,
  output logic                vld_out,
  input  logic                rdy_out,
  output logic [DATASIZE-1:0] dout,
  output logic                last_out,
  output logic                dup_err
);

  localparam logic S_COLLECT = 1'b0;
  localparam logic S_DRAIN   = 1'b1;

  logic                          state_q, state_d;
  logic [5:0]                    wr_cnt_q, wr_cnt_d;
  logic [4:0]                    rd_ptr_q, rd_ptr_d;
  logic                          rdy_q;
  logic [NUM-1:0][DATASIZE-1:0]  slot_q;
  logic                          acc, xfer;

  assign acc  = vld_in && rdy_q && (state_q == S_COLLECT);
  assign xfer = (state_q == S_DRAIN) && rdy_out;

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      state_d  = S_COLLECT;
      wr_cnt_d = '0;
      rd_ptr_d = '0;
    end else if (state_q == S_COLLECT) begin
      if (acc) begin
        if (wr_cnt_q == 6'd31) begin
          state_d  = S_DRAIN;
          wr_cnt_d = '0;
          rd_ptr_d = '0;
        end else begin
          wr_cnt_d = wr_cnt_q + 6'd1;
        end
      end
    end else if (xfer) begin
      if (rd_ptr_q == 5'd31) state_d = S_COLLECT;
      rd_ptr_d = rd_ptr_q + 5'd1;
    end
  end

  // rdy_in is registered so it rises one edge after reset release or drain end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_COLLECT;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      rdy_q    <= 1'b0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= (state_d == S_COLLECT);
      if (acc && !clr) slot_q[score_in] <= din;
    end
  end

  assign rdy_in   = rdy_q;
  assign vld_out  = (state_q == S_DRAIN);
  assign dout     = vld_out ? slot_q[rd_ptr_q] : '0;
  assign last_out = vld_out && (rd_ptr_q == 5'd31);

`ifdef RANK_SCATTER_DUP_CHK_EN
  logic [NUM-1:0] occ_q;
  logic           dup_q;

  // Occupancy restarts with every frame; dup_q survives clr and only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      dup_q <= 1'b0;
    end else if (clr || (state_q == S_DRAIN && state_d == S_COLLECT)) begin
      occ_q <= '0;
    end else if (acc) begin
      occ_q[score_in] <= 1'b1;
      if (occ_q[score_in]) dup_q <= 1'b1;
    end
  end

  assign dup_err = dup_q;
`else
  assign dup_err = 1'b0;
`endif

endmodule

// File: tb/tb_rank_scatter_buf.sv
// Scoreboard bench for rank_scatter_buf: frames pushed as expected rank-ordered
// words; a negedge monitor pops and compares on every output transfer.
module tb_rank_scatter_buf;
  logic       clk = 0, rst_n = 0, clr = 0, vld_in = 0, rdy_out = 1;
  logic [7:0] din = 0;
  logic [4:0] score_in = 0;
  logic       rdy_in, vld_out, last_out, dup_err;
  logic [7:0] dout;

  rank_scatter_buf #(.DATASIZE(8), .NUM(32)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .vld_in(vld_in), .rdy_in(rdy_in),
    .din(din), .score_in(score_in), .vld_out(vld_out), .rdy_out(rdy_out),
    .dout(dout), .last_out(last_out), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

`ifdef RANK_SCATTER_DUP_CHK_EN
  localparam logic DUP_EXP = 1'b1;
`else
  localparam logic DUP_EXP = 1'b0;
`endif

  int         total = 0, bad = 0;
  logic [8:0] expq[$];
  logic [7:0] mslot[32];
  logic [4:0] fr[32];
  logic [7:0] fd[32];
  int         rmode = 0, nxfer = 0, xfer_base = 0, acc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: transfers, stall hold, rdy_in low while draining
  logic       stall_p = 0;
  logic [8:0] stall_v = 0, e;
  always @(negedge clk) if (rst_n) begin
    if (vld_out) chk("rdy_in_in_drain", rdy_in, 0);
    if (stall_p && vld_out) chk("stall_hold", {last_out, dout}, stall_v);
    if (vld_out && rdy_out) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_out: got %0h expected none", {last_out, dout});
      end else begin
        e = expq.pop_front();
        chk("dout_last", {last_out, dout}, e);
        nxfer++;
      end
    end
    stall_p = vld_out && !rdy_out;
    stall_v = {last_out, dout};
  end

  always @(posedge clk) begin
    #1;
    if (rmode == 0) rdy_out = 1;
    else if (rmode == 1) rdy_out = 1'($urandom_range(0, 1));
  end

  task automatic put(input logic [7:0] d, input logic [4:0] r, input int gap);
    int g = 0;
    repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
    vld_in = 1; din = d; score_in = r;
    while (!rdy_in && g < 400) begin @(posedge clk); #1; g++; end
    if (!rdy_in) begin
      total++; bad++;
      $display("FAIL put_timeout: rdy_in stayed 0 expected 1");
      vld_in = 0;
    end else begin
      @(posedge clk); #1;
      vld_in = 0;
      mslot[r] = d;
      acc_cnt++;
      if (acc_cnt == 32) begin
        acc_cnt = 0;
        xfer_base = nxfer;
        for (int k = 0; k < 32; k++) expq.push_back({(k == 31), mslot[k]});
        chk("first_vld_latency", vld_out, 1);
        chk("rdy_in_low_drain", rdy_in, 0);
      end
    end
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < 32; i++) put(fd[i], fr[i], gap);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (expq.size() != 0 && g < 2000) begin @(posedge clk); #1; g++; end
    if (expq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: %0d words left expected 0", expq.size());
      expq.delete();
    end else begin
      @(posedge clk); #1;
      chk("xfer_count", nxfer - xfer_base, 32);
      chk("rdy_back", rdy_in, 1);
    end
  endtask

  task automatic shuffle_ranks();
    logic [4:0] t;
    int j;
    for (int i = 0; i < 32; i++) fr[i] = 5'(i);
    for (int i = 31; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = fr[i]; fr[i] = fr[j]; fr[j] = t;
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mslot[k] = 0;
    #2;
    chk("rst_vld_out", vld_out, 0);
    chk("rst_dout", dout, 0);
    chk("rst_last_out", last_out, 0);
    chk("rst_dup_err", dup_err, 0);
    chk("rst_rdy_in", rdy_in, 0);
    #10 rst_n = 1;
    @(posedge clk); #1;
    chk("rdy_after_rst", rdy_in, 1);

    // ascending
    for (int i = 0; i < 32; i++) begin fr[i] = 5'(i); fd[i] = 8'(100 + i); end
    send_frame(0); wait_drain();

    // reversed
    for (int i = 0; i < 32; i++) begin fr[i] = 5'(31 - i); fd[i] = 8'(i); end
    send_frame(0); wait_drain();

    // random permutation under backpressure
    rmode = 1;
    shuffle_ranks();
    for (int i = 0; i < 32; i++) fd[i] = 8'($urandom);
    send_frame(0); wait_drain();

    // gapped input, then junk while draining
    shuffle_ranks();
    for (int i = 0; i < 32; i++) fd[i] = 8'($urandom);
    send_frame(3);
    vld_in = 1; din = 8'hEE; score_in = 5'd7;
    repeat (10) begin @(posedge clk); #1; end
    vld_in = 0;
    wait_drain();
    // rank 7 missing from this frame, so slot 7 must still hold the old word
    rmode = 0;
    for (int i = 0; i < 32; i++) begin fr[i] = (i == 7) ? 5'd8 : 5'(i); fd[i] = 8'(200 + i); end
    send_frame(1); wait_drain();

    // clr after 10 accepts, then full frame
    for (int i = 0; i < 10; i++) put(8'(50 + i), 5'(i), 0);
    clr = 1; @(posedge clk); #1; clr = 0; acc_cnt = 0;
    chk("clr_collect_vld", vld_out, 0);
    chk("clr_collect_rdy", rdy_in, 1);
    for (int i = 0; i < 32; i++) begin fr[i] = 5'(31 - i); fd[i] = 8'(60 + i); end
    send_frame(0); wait_drain();

    // clr during drain at rd_ptr=5
    rmode = 2; rdy_out = 0;
    for (int i = 0; i < 32; i++) begin fr[i] = 5'(i); fd[i] = 8'(150 + i); end
    send_frame(0);
    rdy_out = 1;
    repeat (5) begin @(posedge clk); #1; end
    rdy_out = 0;
    chk("dout_rd5", dout, 155);
    clr = 1; @(posedge clk); #1; clr = 0;
    chk("clr_drain_vld", vld_out, 0);
    chk("clr_drain_rdy", rdy_in, 1);
    chk("clr_drain_last", last_out, 0);
    expq.delete();

    // reset mid-drain
    shuffle_ranks();
    for (int i = 0; i < 32; i++) fd[i] = 8'($urandom_range(1, 255));
    rdy_out = 1;
    send_frame(0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 0; #1;
    chk("rst_mid_vld", vld_out, 0);
    chk("rst_mid_dout", dout, 0);
    chk("rst_mid_last", last_out, 0);
    chk("rst_mid_rdy", rdy_in, 0);
    chk("rst_mid_dup", dup_err, 0);
    expq.delete(); acc_cnt = 0;
    for (int k = 0; k < 32; k++) mslot[k] = 0;
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk("rdy_after_rst2", rdy_in, 1);
    rmode = 0;

    // duplicate rank 3 (rank 4 never written, stays 0 since reset)
    for (int i = 0; i < 32; i++) begin fr[i] = (i == 4) ? 5'd3 : 5'(i); fd[i] = 8'(70 + i); end
    send_frame(0);
    chk("dup_err_frame", dup_err, DUP_EXP);
    chk("slot3_dout_ahead", mslot[3], 74);
    wait_drain();
    clr = 1; @(posedge clk); #1; clr = 0;
    chk("dup_err_after_clr", dup_err, DUP_EXP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
